// File: rtl/cpu_pkg.sv
// cpu_pkg: shared cpu opcodes, data width and the dmem responder state encoding.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_STW = 5'b10010;
  localparam logic [4:0] OP_LDW = 5'b10011;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word array, synchronous write, asynchronous read; contents are never reset.
module dmem_array import cpu_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge CLK)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready load/store responder with programmable wait states.
// Define DMEM_MMIO_EN to map the top word address onto the mmio_out register.
module dmem_responder import cpu_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mmio_out
);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  dmem_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, mem_rdata, ld_data;
  logic accept, done, fire, is_st, is_ld, mmio_hit, we;
  assign req_ready = state == ST_IDLE;
  assign rsp_valid = state == ST_RESP;
  assign accept = req_valid && req_ready;
  assign done = state == ST_ACCESS && cnt == 4'd0;
  assign fire = rsp_valid && rsp_ready;
  assign is_st = op == OP_STW;
  assign is_ld = op == OP_LDW;
  assign we = done && is_st && !mmio_hit;
`ifdef DMEM_MMIO_EN
  logic [DATA_W-1:0] mmio_q;
  assign mmio_hit = addr == {ADDR_W{1'b1}};
  assign ld_data = mmio_hit ? mmio_q : mem_rdata;
  assign mmio_out = mmio_q;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) mmio_q <= '0;
    else if (done && is_st && mmio_hit) mmio_q <= wdata;
`else
  assign mmio_hit = 1'b0;
  assign ld_data = mem_rdata;
  assign mmio_out = '0;
`endif
  always_comb begin
    state_n = accept ? ST_ACCESS : done ? ST_RESP : fire ? ST_IDLE : state;
    cnt_n = accept ? WC : (state == ST_ACCESS && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // request fields only matter once accepted, so they need no reset
  always_ff @(posedge CLK)
    if (accept) begin
      op <= req_op;
      addr <= req_addr;
      wdata <= req_wdata;
    end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else if (done) begin
      rsp_rdata <= is_ld ? ld_data : '0;
      rsp_err <= !(is_st || is_ld);
    end else if (fire) begin
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .CLK(CLK),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(mem_rdata)
  );
endmodule
